// File: rtl/store_trace_pkg.sv
// Shared types and helpers for the store trace capture/display block.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package store_trace_pkg;

    // Presentation sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        SHOW = 2'd2
    } state_t;

    // Decimal digits needed to hold any value of the given bit width,
    // i.e. ceil(bits * log10(2)). 30103/100000 overestimates log10(2) by
    // about 4e-9, which only matters for widths far beyond any real bus.
    function automatic int bcd_digits(input int bits);
        return (bits * 30103 + 99999) / 100000;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Default-width trace entry layout (address in the upper field).
    localparam int TRACE_ADDR_BITS = 10;
    localparam int TRACE_DATA_BITS = 10;

    typedef struct packed {
        logic [TRACE_ADDR_BITS-1:0] addr;
        logic [TRACE_DATA_BITS-1:0] data;
    } trace_entry_t;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous trace FIFO that overwrites its oldest entry when full.
// Latency: push visible in count on the push edge; pop_dat is the combinational head.
// Backpressure: none; a push into a full FIFO without a pop drops the oldest entry and pulses dropped.
//
// Ports: clk/reset (sync, active-high); push/push_dat write side; pop/pop_dat
// read side (pop ignored when empty); count = occupancy; dropped = overwrite pulse.
module trace_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_dat,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       dropped
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             full;
    logic             empty;
    logic             do_pop;
    logic             overwrite;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign do_pop    = pop && !empty;
    // When full, wr_ptr == rd_ptr, so the write lands on the oldest entry and
    // the read pointer must skip past it.
    assign overwrite = push && full && !do_pop;
    assign dropped   = overwrite;
    assign pop_dat   = mem[rd_ptr];

    // Storage is not reset; occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop || overwrite) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !do_pop && !full) begin
                count <= count + CW'(1);
            end else if (do_pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/store_trace_display.sv
// Captures core stores into a trace FIFO and presents each one as BCD for a hold time.
// Latency: store at edge E0 -> popped at E0+1 -> BCD latched at E0+1+W.
// Backpressure: none; full FIFO overwrites oldest (drop_cnt), freeze discards stores silently.
//
// Ports: clk/reset (sync, active-high); mem_write/data_addr/write_data store tap;
// freeze pauses capture and hold timer; step ends the current hold early;
// addr_bcd/data_bcd presented digits (nibble 0 = units); disp_valid sticky after
// first presentation; disp_new one-cycle update pulse; pending FIFO occupancy;
// drop_cnt saturating overwrite count.
module store_trace_display
    import store_trace_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_BITS   = 10,
    parameter int DATA_BITS   = 10,
    parameter int ADDR_DIGITS = 3,
    parameter int DATA_DIGITS = 2,
    parameter int DEPTH       = 8,
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       mem_write,
    input  logic [DATA_WIDTH-1:0]      data_addr,
    input  logic [DATA_WIDTH-1:0]      write_data,
    input  logic                       freeze,
    input  logic                       step,
    output logic [4*ADDR_DIGITS-1:0]   addr_bcd,
    output logic [4*DATA_DIGITS-1:0]   data_bcd,
    output logic                       disp_valid,
    output logic                       disp_new,
    output logic [$clog2(DEPTH+1)-1:0] pending,
    output logic [7:0]                 drop_cnt
);
    // Conversion length and internal BCD sizes. The internal registers are
    // never narrower than the presented digit count, so unused upper digits
    // simply read as zero.
    localparam int W   = max_int(ADDR_BITS, DATA_BITS);
    localparam int ABD = max_int(bcd_digits(ADDR_BITS), ADDR_DIGITS);
    localparam int DBD = max_int(bcd_digits(DATA_BITS), DATA_DIGITS);
    localparam int SCW = $clog2(W+1);
    localparam int HW  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int EW  = ADDR_BITS + DATA_BITS;

    // ---------------------------------------------------------------- capture
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_dropped;
    logic [EW-1:0] fifo_head;

    assign fifo_push = mem_write && !freeze;

    trace_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (fifo_push),
        .push_dat ({data_addr[ADDR_BITS-1:0], write_data[DATA_BITS-1:0]}),
        .pop      (fifo_pop),
        .pop_dat  (fifo_head),
        .count    (pending),
        .dropped  (fifo_dropped)
    );

    // Upper bus bits are intentionally not captured.
    logic unused_hi_bits;
    assign unused_hi_bits = ^{data_addr[DATA_WIDTH-1:ADDR_BITS],
                              write_data[DATA_WIDTH-1:DATA_BITS]};

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt <= '0;
        end else if (fifo_dropped && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

    // -------------------------------------------------------------- sequencer
    state_t         state;
    state_t         state_next;
    logic [SCW-1:0] step_cnt;
    logic [HW-1:0]  hold;
    logic           conv_en;
    logic           latch;
    logic           hold_dec;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        fifo_pop   = 1'b0;
        conv_en    = 1'b0;
        latch      = 1'b0;
        hold_dec   = 1'b0;
        case (state)
            IDLE: begin
                if (pending != '0) begin
                    fifo_pop   = 1'b1;
                    state_next = CONV;
                end
            end
            CONV: begin
                // Freeze deliberately does not stall the conversion.
                conv_en = 1'b1;
                if (step_cnt == SCW'(W-1)) begin
                    latch      = 1'b1;
                    state_next = SHOW;
                end
            end
            SHOW: begin
                // Freeze pauses the timer and also masks step and expiry.
                if (!freeze) begin
                    if ((hold == '0) || step) begin
                        state_next = IDLE;
                    end else begin
                        hold_dec = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ----------------------------------------------------- double-dabble step
    logic [W-1:0]     addr_sr;
    logic [W-1:0]     data_sr;
    logic [4*ABD-1:0] addr_acc;
    logic [4*DBD-1:0] data_acc;
    logic [4*ABD-1:0] addr_adj;
    logic [4*DBD-1:0] data_adj;
    logic [4*ABD-1:0] addr_acc_nxt;
    logic [4*DBD-1:0] data_acc_nxt;

    // Add 3 to every digit >= 5, then shift in the next binary MSB.
    always_comb begin
        addr_adj = addr_acc;
        for (int i = 0; i < ABD; i++) begin
            if (addr_adj[4*i +: 4] >= 4'd5) begin
                addr_adj[4*i +: 4] = addr_adj[4*i +: 4] + 4'd3;
            end
        end
        addr_acc_nxt = {addr_adj[4*ABD-2:0], addr_sr[W-1]};
    end

    always_comb begin
        data_adj = data_acc;
        for (int i = 0; i < DBD; i++) begin
            if (data_adj[4*i +: 4] >= 4'd5) begin
                data_adj[4*i +: 4] = data_adj[4*i +: 4] + 4'd3;
            end
        end
        data_acc_nxt = {data_adj[4*DBD-2:0], data_sr[W-1]};
    end

    // --------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_sr    <= '0;
            data_sr    <= '0;
            addr_acc   <= '0;
            data_acc   <= '0;
            step_cnt   <= '0;
            hold       <= '0;
            addr_bcd   <= '0;
            data_bcd   <= '0;
            disp_valid <= 1'b0;
            disp_new   <= 1'b0;
        end else begin
            disp_new <= latch;
            if (fifo_pop) begin
                // Narrower field is zero-extended on the MSB side.
                addr_sr  <= W'(fifo_head[EW-1:DATA_BITS]);
                data_sr  <= W'(fifo_head[DATA_BITS-1:0]);
                addr_acc <= '0;
                data_acc <= '0;
                step_cnt <= '0;
            end
            if (conv_en) begin
                addr_sr  <= addr_sr << 1;
                data_sr  <= data_sr << 1;
                addr_acc <= addr_acc_nxt;
                data_acc <= data_acc_nxt;
                step_cnt <= step_cnt + SCW'(1);
            end
            if (latch) begin
                // Only the low digits are shown: the value displayed is mod 10^digits.
                addr_bcd   <= addr_acc_nxt[4*ADDR_DIGITS-1:0];
                data_bcd   <= data_acc_nxt[4*DATA_DIGITS-1:0];
                disp_valid <= 1'b1;
                hold       <= HW'(HOLD_CYCLES-1);
            end else if (hold_dec) begin
                hold <= hold - HW'(1);
            end
        end
    end

endmodule
